// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and constants for the serial TX scheduler
// Contents: tx_state_t frame-sequencer states, DATA_BITS, CNT_W, START_LEVEL, STOP_LEVEL.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam int CNT_W = $clog2(DATA_BITS);

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports: req[N] requests in; last[GW] previous winner in; en in;
//        grant[N] one-hot winner out; grant_idx[GW] winner index out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [GW-1:0] grant_idx
);

  logic [GW-1:0] idx;
  logic          found;

  // Search upward starting just after the previous winner, wrapping modulo N;
  // the previous winner itself is visited last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = GW'((int'(last) + i) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - round-robin sharing of one serial TX line among N_REQ byte requesters
// Ports: clk, reset (sync, active-high); req_valid[N_REQ], req_data[8*N_REQ] in;
//        req_ready[N_REQ] one-hot accept out; tx serial line out (idle high);
//        busy out; grant_id[GW] index of most recently accepted requester out.
// Frame: start 0, 8 data bits LSB first, odd parity, stop 1.
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_BITS - 1);
  localparam logic [GW-1:0]    LAST_RESET = GW'(N_REQ - 1);

  tx_state_t              state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [GW-1:0]          last_q, last_d;
  logic [GW-1:0]          gid_q, gid_d;
  logic                   tx_q, tx_d;

  logic                   grant_win;
  logic                   arb_en;
  logic [N_REQ-1:0]       grant;
  logic [GW-1:0]          grant_idx;
  logic                   any_grant;
  logic [DATA_BITS-1:0]   sel_byte;

  // IDLE and STOP are both grant windows so frames can run back-to-back.
  assign grant_win = (state_q == IDLE) || (state_q == STOP);
  assign arb_en    = grant_win && !reset;

  rr_arbiter #(
    .N  (N_REQ),
    .GW (GW)
  ) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_byte = req_data[8*i +: 8];
    end
  end

  // tx is registered: tx_d is the line level belonging to the state being
  // entered, so the line always matches the registered state.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    bitcnt_d = bitcnt_q;
    last_d   = last_q;
    gid_d    = gid_q;
    tx_d     = tx_q;
    case (state_q)
      IDLE, STOP: begin
        if (any_grant) begin
          state_d = START;
          shreg_d = sel_byte;
          par_d   = ~^sel_byte;
          last_d  = grant_idx;
          gid_d   = grant_idx;
          tx_d    = START_LEVEL;
        end else begin
          state_d = IDLE;
          tx_d    = STOP_LEVEL;
        end
      end
      START: begin
        state_d  = DATA;
        tx_d     = shreg_q[0];
        shreg_d  = shreg_q >> 1;
        bitcnt_d = '0;
      end
      DATA: begin
        if (bitcnt_q == LAST_BIT) begin
          state_d = PARITY;
          tx_d    = par_q;
        end else begin
          tx_d     = shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_LEVEL;
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      bitcnt_q <= '0;
      last_q   <= LAST_RESET;
      gid_q    <= '0;
      tx_q     <= STOP_LEVEL;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      bitcnt_q <= bitcnt_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb/tb_serial_tx_scheduler.sv - self-checking bench for serial_tx_scheduler
module tb_serial_tx_scheduler;

  localparam int N  = 4;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic           busy;
  logic [GW-1:0]  grant_id;

  serial_tx_scheduler #(.N_REQ(N), .GW(GW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int          id;
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t        sb[$];
  logic [7:0]  rq[N][$];
  logic [N-1:0] hs_mask = '0;

  int          pos = 11;
  logic [10:0] exp_frame = '0;
  logic [10:0] cap_frame = '0;
  bit          rst_prev = 1'b1;
  bit          have_prev = 1'b0;
  bit          expect_gap = 1'b0;
  int          prev_hs = 0;
  int          last_hs_cyc = 0;
  int          hs_count = 0;
  bit          gid_pend = 1'b0;
  int          gid_exp = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: present the head of each queue, pop after acceptance.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (hs_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    hs_mask = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  end

  // Monitor: line checking and scoreboard pops on each handshake.
  always @(negedge clk) begin
    logic [N-1:0] hs;
    exp_t         e;
    logic         par;
    if (rst_prev) begin
      pos       = 11;
      have_prev = 1'b0;
      gid_pend  = 1'b0;
    end
    if (gid_pend) begin
      check(grant_id == GW'(gid_exp), "grant_id", grant_id, gid_exp);
      gid_pend = 1'b0;
    end
    if (reset) check(req_ready == '0, "ready_in_reset", req_ready, 0);
    if (pos < 11) begin
      check(tx == exp_frame[pos], "tx_bit", tx, exp_frame[pos]);
      check(busy == 1'b1, "busy_in_frame", busy, 1);
      cap_frame[pos] = tx;
      pos++;
    end else begin
      check(tx == 1'b1 && busy == 1'b0, "line_idle", {tx, busy}, 2'b10);
    end
    hs = req_valid & req_ready;
    if (hs != '0) begin
      check(pos >= 11, "grant_in_window", pos, 11);
      check(sb.size() != 0, "unexpected_grant", hs, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(hs == (N'(1) << e.id), "grant_onehot", hs, N'(1) << e.id);
        par = ($countones(e.data) % 2 == 0);
        exp_frame = {1'b1, par, e.data, 1'b0};
        pos = 0;
        gid_exp = e.id;
        gid_pend = 1'b1;
      end
      if (expect_gap && have_prev) check(cyc - prev_hs == 11, "grant_gap", cyc - prev_hs, 11);
      prev_hs     = cyc;
      have_prev   = 1'b1;
      last_hs_cyc = cyc;
      hs_count++;
      hs_mask = hs_mask | hs;
    end
    rst_prev = reset;
  end

  function automatic bit rq_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (n < budget && !(sb.size() == 0 && pos >= 11 && rq_empty())) begin
      tick();
      n++;
    end
    check(n < budget, "idle_timeout", n, budget);
  endtask

  task automatic wait_hs(input int k);
    int n = 0;
    while (n < 100 && hs_count < k) begin
      tick();
      n++;
    end
    check(hs_count >= k, "hs_timeout", hs_count, k);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    rq[id].push_back(d);
    e.id = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int t;
    vecs[0] = '{0, 8'h4B, {1'b1, 1'b1, 8'h4B, 1'b0}};
    vecs[1] = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[2] = '{2, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
    vecs[3] = '{3, 8'h01, {1'b1, 1'b0, 8'h01, 1'b0}};
    vecs[4] = '{0, 8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
    vecs[5] = '{2, 8'h5A, {1'b1, 1'b1, 8'h5A, 1'b0}};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check(tx == 1'b1, "rst_tx", tx, 1);
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(req_ready == '0, "rst_ready", req_ready, 0);
    check(grant_id == '0, "rst_grant_id", grant_id, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single bytes and parity corners
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].id, vecs[i].data);
      wait_idle(40);
      check(cap_frame == vecs[i].frame, "frame", cap_frame, vecs[i].frame);
      check(cap_frame[9] == vecs[i].frame[9], "parity", cap_frame[9], vecs[i].frame[9]);
      check(grant_id == GW'(vecs[i].id), "tbl_grant_id", grant_id, vecs[i].id);
    end

    // Fairness: all requesters held, order 0,1,2,3,0 at 11-cycle spacing
    do_reset();
    t = hs_count;
    expect_gap = 1'b1;
    push(0, 8'hA1);
    push(1, 8'hB2);
    push(2, 8'hC3);
    push(3, 8'hD4);
    sb.push_back('{0, 8'hE5});
    rq[0].push_back(8'hE5);
    wait_idle(120);
    check(hs_count - t == 5, "fair_count", hs_count - t, 5);
    expect_gap = 1'b0;

    // Pointer continuity: 2 served, 1 and 3 arrive mid-frame -> 3 then 1
    do_reset();
    t = hs_count;
    push(2, 8'h3C);
    wait_hs(t + 1);
    wait_cyc(last_hs_cyc + 4);
    expect_gap = 1'b1;
    rq[1].push_back(8'h11);
    rq[3].push_back(8'h33);
    sb.push_back('{3, 8'h33});
    sb.push_back('{1, 8'h11});
    wait_idle(80);
    expect_gap = 1'b0;

    // Reset during data bit 4 with requester 1 pending
    do_reset();
    t = hs_count;
    push(2, 8'hA5);
    wait_hs(t + 1);
    wait_cyc(last_hs_cyc + 2);
    rq[1].push_back(8'h66);
    wait_cyc(last_hs_cyc + 6);
    reset = 1'b1;
    rq[0].push_back(8'h99);
    @(negedge clk);
    @(negedge clk);
    check(tx == 1'b1, "midrst_tx", tx, 1);
    check(busy == 1'b0, "midrst_busy", busy, 0);
    check(req_ready == '0, "midrst_ready", req_ready, 0);
    tick();
    reset = 1'b0;
    sb.push_back('{0, 8'h99});
    sb.push_back('{1, 8'h66});
    expect_gap = 1'b1;
    wait_idle(80);
    expect_gap = 1'b0;

    // Late arrival exactly in the STOP cycle
    do_reset();
    t = hs_count;
    push(0, 8'hC3);
    wait_hs(t + 1);
    wait_cyc(last_hs_cyc + 11);
    t = last_hs_cyc;
    push(3, 8'h5A);
    wait_idle(60);
    check(last_hs_cyc - t == 11, "late_accept", last_hs_cyc - t, 11);

    check(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
